// File: rtl/buffer_column_to_row.sv
// 9x9 column-to-row reorder buffer: collects nine 9-sample columns, then emits the block row by row.
// Optional double-buffered streaming mode: define BUFFER_COLUMN_TO_ROW_PINGPONG_EN.
module buffer_column_to_row #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH+1:0] in_0,
  input  logic signed [DATA_WIDTH+1:0] in_1,
  input  logic signed [DATA_WIDTH+1:0] in_2,
  input  logic signed [DATA_WIDTH+1:0] in_3,
  input  logic signed [DATA_WIDTH+1:0] in_4,
  input  logic signed [DATA_WIDTH+1:0] in_5,
  input  logic signed [DATA_WIDTH+1:0] in_6,
  input  logic signed [DATA_WIDTH+1:0] in_7,
  input  logic signed [DATA_WIDTH+1:0] in_8,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH+1:0] out_0,
  output logic signed [DATA_WIDTH+1:0] out_1,
  output logic signed [DATA_WIDTH+1:0] out_2,
  output logic signed [DATA_WIDTH+1:0] out_3,
  output logic signed [DATA_WIDTH+1:0] out_4,
  output logic signed [DATA_WIDTH+1:0] out_5,
  output logic signed [DATA_WIDTH+1:0] out_6,
  output logic signed [DATA_WIDTH+1:0] out_7,
  output logic signed [DATA_WIDTH+1:0] out_8,
  output logic [3:0]                   out_row,
  output logic                         out_last,
  output logic                         busy
);

  localparam int unsigned SW = DATA_WIDTH + 2;
  localparam int unsigned N  = 9;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  logic signed [SW-1:0] col_in [N];
  logic signed [SW-1:0] rd_row [N];
  logic [CW-1:0]        col_cnt;
  logic [CW-1:0]        row_cnt;
  logic                 in_fire;
  logic                 out_fire;

  assign col_in[0] = in_0;
  assign col_in[1] = in_1;
  assign col_in[2] = in_2;
  assign col_in[3] = in_3;
  assign col_in[4] = in_4;
  assign col_in[5] = in_5;
  assign col_in[6] = in_6;
  assign col_in[7] = in_7;
  assign col_in[8] = in_8;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef BUFFER_COLUMN_TO_ROW_PINGPONG_EN
  // Two banks; each bank's flag says whether it is filling or holds a complete block.
  state_t               bank_state [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic signed [SW-1:0] mem [2][N][N];

  // A fill can only target a FILL bank and a drain only a DRAIN bank, so the
  // pointers never collide when both transfers land in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_state[0] <= FILL;
      bank_state[1] <= FILL;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
    end else begin
      if (in_fire) begin
        if (col_cnt == LAST) begin
          bank_state[wr_ptr] <= DRAIN;
          wr_ptr             <= ~wr_ptr;
          col_cnt            <= '0;
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      if (out_fire) begin
        if (row_cnt == LAST) begin
          bank_state[rd_ptr] <= FILL;
          rd_ptr             <= ~rd_ptr;
          row_cnt            <= '0;
        end else begin
          row_cnt <= row_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (in_fire) begin
      for (int k = 0; k < N; k++) mem[wr_ptr][k][col_cnt] <= col_in[k];
    end
  end

  assign in_ready  = (bank_state[wr_ptr] == FILL);
  assign out_valid = (bank_state[rd_ptr] == DRAIN);
  assign busy      = (bank_state[0] == DRAIN) || (bank_state[1] == DRAIN) || (col_cnt != '0);

  always_comb begin
    for (int k = 0; k < N; k++) rd_row[k] = '0;
    if (out_valid) begin
      for (int k = 0; k < N; k++) rd_row[k] = mem[rd_ptr][row_cnt][k];
    end
  end
`else
  state_t               state;
  logic signed [SW-1:0] mem [N][N];

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FILL;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (col_cnt == LAST) begin
              state   <= DRAIN;
              col_cnt <= '0;
              row_cnt <= '0;
            end else begin
              col_cnt <= col_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (row_cnt == LAST) begin
              state   <= FILL;
              row_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + CW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Storage is not reset; a partial block is discarded simply by restarting col_cnt.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      for (int k = 0; k < N; k++) mem[k][col_cnt] <= col_in[k];
    end
  end

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN) || (col_cnt != '0);

  always_comb begin
    for (int k = 0; k < N; k++) rd_row[k] = '0;
    if (out_valid) begin
      for (int k = 0; k < N; k++) rd_row[k] = mem[row_cnt][k];
    end
  end
`endif

  assign out_row  = out_valid ? row_cnt : '0;
  assign out_last = out_valid && (row_cnt == LAST);

  assign out_0 = rd_row[0];
  assign out_1 = rd_row[1];
  assign out_2 = rd_row[2];
  assign out_3 = rd_row[3];
  assign out_4 = rd_row[4];
  assign out_5 = rd_row[5];
  assign out_6 = rd_row[6];
  assign out_7 = rd_row[7];
  assign out_8 = rd_row[8];

endmodule
